lsu: RTL and testbench
======================

Name: lsu

Overview:
- Load/store unit directly upstream of the unified word-addressed memory in the multicycle RISC-V core.
- Accepts one byte, half or word request at a time from the execute stage.
- Generates word-aligned memory accesses with byte strobes, splitting a request that crosses a word boundary into two accesses.
- Merges, shifts and sign- or zero-extends load data, then returns a single response.

Parameters:
- ALLOW_MISALIGNED, 1: 1 = split word-crossing accesses; 0 = reject any non-naturally-aligned access with resp_err.
- WORD_ADDR_W, 30: width of the memory word index. Byte address bits [WORD_ADDR_W+1:2].

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle, can accept a request
- req_is_store  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  in  1  zero-extend load (lbu/lhu)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  valid with resp_valid: misaligned (when disallowed) or reserved size
- resp_rdata  out  32  extended load data; 0 for stores and errors
- mem_en  out  1  memory access this cycle
- mem_we  out  1  write
- mem_wstrb  out  4  byte lanes written
- mem_addr  out  WORD_ADDR_W  word index
- mem_wdata  out  32  lane-aligned write data
- mem_rdata  in  32  valid the cycle after mem_en; memory holds it until the next read

Behaviour:
- **States:** IDLE, LO, HI, RESP. req_ready = (state==IDLE) && !rst. Handshake: req_valid && req_ready at edge T latches addr, size, unsigned, is_store, wdata.
- **Lane computation** (on latched fields):
  - off = addr[1:0]; szmask = 1/3/F for byte/half/word.
  - strobe8 = szmask << off; wdata64 = wdata << (8*off).
  - split = strobe8[7:4] != 0.
- **Error check:** err = size==11, or (!ALLOW_MISALIGNED && addr not aligned to size).
- **Transitions from IDLE on accept:**
  - err → RESP at T+1. No mem_en is ever raised.
  - otherwise → LO at T+1.
- **LO:**
  - Drives mem_en=1, mem_we=is_store, mem_addr=addr word index, mem_wstrb=strobe8[3:0], mem_wdata=wdata64[31:0].
  - Loads drive mem_wstrb=0.
  - Next state is HI if split, else RESP.
- **HI:**
  - Drives mem_en=1, mem_addr = word index+1 (wraps modulo 2^WORD_ADDR_W), mem_wstrb=strobe8[7:4], mem_wdata=wdata64[63:32].
  - On the edge, captures mem_rdata (the low word) into lo_buf.
  - Next state is RESP.
- **RESP:**
  - resp_valid=1 for exactly this cycle; next state is IDLE.
  - Load data: rd64 = split ? {mem_rdata, lo_buf} : {32'b0, mem_rdata}. Take (rd64 >> 8*off) truncated to size, then sign-extend (unless unsigned).
  - resp_rdata=0 for stores and errors; resp_err as computed.
- **Latency** (accept at T): aligned → resp at T+2; split → T+3; error → T+1. Next accept earliest is the cycle after RESP.
- **Stores:** resp_valid acts as write acknowledge.
- **Idle outputs:** mem_en, mem_we, mem_wstrb, mem_wdata and mem_addr are all 0 whenever state is IDLE or RESP.
- **Reset (any state, including mid-split):**
  - Next cycle state=IDLE, resp_valid=0, resp_err=0, resp_rdata=0, mem_en=0, lo_buf=0.
  - No response is ever produced for an interrupted request.
  - A partially written split store is not rolled back.
- **Invariants:**
  - resp_valid is never high in the same cycle as mem_en.
  - Requests are ignored while req_ready=0.

Decomposition:
- Package lsu_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W;
  - state enum IDLE/LO/HI/RESP;
  - the szmask function.
- One combinational sub-module, lsu_align, holds all shift/merge/extend logic: strobe8, wdata64 and the rd64 extraction/extension.
- The FSM and request/lo_buf registers stay in lsu.

Test Plan:
Memory preloaded with word 0x10=0x8899AABB, 0x11=0x11223344.
1. lw 0x40 → one mem_en at T+1 (addr 0x10, wstrb 0); resp_valid at T+2 with rdata 0x8899AABB, err 0.
2. lb 0x43 → rdata 0xFFFFFF88; lbu 0x43 → 0x00000088; lh 0x42 → 0xFFFF8899; lhu 0x42 → 0x00008899.
3. ALLOW_MISALIGNED=1:
   - lh 0x43 → mem_en addr 0x10 at T+1, then addr 0x11 at T+2; resp at T+3 rdata 0x00004488.
   - lw 0x42 → rdata 0x33448899.
4. sw 0x46 data 0xDEADBEEF → T+1: addr 0x11, wstrb C, wdata 0xBEEF0000; T+2: addr 0x12, wstrb 3, wdata 0x0000DEAD; resp T+3. A readback lw 0x44 → 0xBEEF3344.
5. ALLOW_MISALIGNED=0: lh 0x43 → resp_valid T+1, err=1, rdata 0, mem_en never high. Size=11 at 0x40 → err=1 under either setting.
6. Assert rst during HI of a split load → next cycle IDLE, mem_en=0, no resp_valid; req_ready=1 the first cycle after rst drops. A fresh lw 0x44 then returns 0x11223344.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit.
// Size codes, FSM state codes, and the lane-mask and request-check functions.
package lsu_pkg;

  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_RSV = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LO   = 2'd1;
  localparam state_t ST_HI   = 2'd2;
  localparam state_t ST_RESP = 2'd3;

  function automatic logic [3:0] szmask(input logic [1:0] size);
    logic [3:0] m;
    case (size)
      SZ_B:    m = 4'h1;
      SZ_H:    m = 4'h3;
      SZ_W:    m = 4'hF;
      default: m = 4'h0;
    endcase
    return m;
  endfunction

  // A reserved size is always an error; alignment matters only when splitting is disabled.
  function automatic logic req_err(input logic [1:0] size, input logic [1:0] off,
                                   input logic allow_misaligned);
    logic misaligned;
    case (size)
      SZ_H:    misaligned = off[0];
      SZ_W:    misaligned = |off;
      default: misaligned = 1'b0;
    endcase
    return (size == SZ_RSV) || (!allow_misaligned && misaligned);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the load/store unit: store strobes and data shifted to byte
// lanes across two words, and load-data merge, right-shift and extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] lo_buf,
  input  logic [31:0] mem_rdata,
  output logic [7:0]  strobe8,
  output logic [63:0] wdata64,
  output logic        split,
  output logic [31:0] load_data
);

  logic [63:0] rd64;
  logic [31:0] rd_sh;

  always_comb begin
    strobe8 = {4'b0000, szmask(size)} << off;
    wdata64 = {32'b0, wdata} << {off, 3'b000};
    split   = |strobe8[7:4];
    // Split loads: the low word was buffered during HI, the high word is live now.
    rd64    = split ? {mem_rdata, lo_buf} : {32'b0, mem_rdata};
    rd_sh   = 32'(rd64 >> {off, 3'b000});
    case (size)
      SZ_B:    load_data = is_unsigned ? {24'b0, rd_sh[7:0]}
                                       : {{24{rd_sh[7]}}, rd_sh[7:0]};
      SZ_H:    load_data = is_unsigned ? {16'b0, rd_sh[15:0]}
                                       : {{16{rd_sh[15]}}, rd_sh[15:0]};
      default: load_data = rd_sh;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit in front of the word-addressed memory: one request at a time,
// split into up to two word accesses, single completion pulse per request.
module lsu
  import lsu_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1,
  parameter int WORD_ADDR_W      = 30
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_is_store,
  input  logic [1:0]             req_size,
  input  logic                   req_unsigned,
  input  logic [31:0]            req_addr,
  input  logic [31:0]            req_wdata,
  output logic                   resp_valid,
  output logic                   resp_err,
  output logic [31:0]            resp_rdata,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [3:0]             mem_wstrb,
  output logic [WORD_ADDR_W-1:0] mem_addr,
  output logic [31:0]            mem_wdata,
  input  logic [31:0]            mem_rdata
);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        st_q, st_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] lo_buf_q, lo_buf_d;

  logic                   accept;
  logic [WORD_ADDR_W-1:0] word_idx;
  logic [7:0]             strobe8;
  logic [63:0]            wdata64;
  logic                   split;
  logic [31:0]            load_data;

  assign req_ready = (state_q == ST_IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign word_idx  = addr_q[WORD_ADDR_W+1:2];

  lsu_align u_align (
    .size        (size_q),
    .off         (addr_q[1:0]),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .lo_buf      (lo_buf_q),
    .mem_rdata   (mem_rdata),
    .strobe8     (strobe8),
    .wdata64     (wdata64),
    .split       (split),
    .load_data   (load_data)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    uns_d    = uns_q;
    st_d     = st_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    lo_buf_d = lo_buf_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d  = req_addr;
          size_d  = req_size;
          uns_d   = req_unsigned;
          st_d    = req_is_store;
          wdata_d = req_wdata;
          err_d   = req_err(req_size, req_addr[1:0], ALLOW_MISALIGNED);
          state_d = err_d ? ST_RESP : ST_LO;
        end
      end
      ST_LO:   state_d = split ? ST_HI : ST_RESP;
      ST_HI: begin
        lo_buf_d = mem_rdata;
        state_d  = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      st_q     <= 1'b0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      lo_buf_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      st_q     <= st_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      lo_buf_q <= lo_buf_d;
    end
  end

  // Loads never assert strobes; the high access wraps at the top of the word space.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_wstrb = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      ST_LO: begin
        mem_en    = 1'b1;
        mem_we    = st_q;
        mem_addr  = word_idx;
        mem_wstrb = st_q ? strobe8[3:0] : 4'b0000;
        mem_wdata = wdata64[31:0];
      end
      ST_HI: begin
        mem_en    = 1'b1;
        mem_we    = st_q;
        mem_addr  = word_idx + WORD_ADDR_W'(1);
        mem_wstrb = st_q ? strobe8[7:4] : 4'b0000;
        mem_wdata = wdata64[63:32];
      end
      default: ;
    endcase
  end

  assign resp_valid = (state_q == ST_RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !err_q && !st_q) ? load_data : 32'b0;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: instance A splits misaligned accesses, instance B rejects them.
module tb_lsu;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid_a, req_valid_b;
  logic        req_is_store, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  logic        req_ready_a, resp_valid_a, resp_err_a, mem_en_a, mem_we_a;
  logic [31:0] resp_rdata_a, mem_wdata_a, mem_rdata_a;
  logic [3:0]  mem_wstrb_a;
  logic [29:0] mem_addr_a;

  logic        req_ready_b, resp_valid_b, resp_err_b, mem_en_b, mem_we_b;
  logic [31:0] resp_rdata_b, mem_wdata_b;
  logic [31:0] mem_rdata_b = 32'h0;
  logic [3:0]  mem_wstrb_b;
  logic [29:0] mem_addr_b;

  lsu #(.ALLOW_MISALIGNED(1'b1), .WORD_ADDR_W(30)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_is_store(req_is_store), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid_a),
    .resp_err(resp_err_a), .resp_rdata(resp_rdata_a), .mem_en(mem_en_a),
    .mem_we(mem_we_a), .mem_wstrb(mem_wstrb_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a)
  );

  lsu #(.ALLOW_MISALIGNED(1'b0), .WORD_ADDR_W(30)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_is_store(req_is_store), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid_b),
    .resp_err(resp_err_b), .resp_rdata(resp_rdata_b), .mem_en(mem_en_b),
    .mem_we(mem_we_b), .mem_wstrb(mem_wstrb_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
  );

  // Memory model for instance A; reset restores the preload image.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h10] <= 32'h8899AABB;
      mem[8'h11] <= 32'h11223344;
    end else if (mem_en_a) begin
      if (mem_we_a) begin
        for (int l = 0; l < 4; l++)
          if (mem_wstrb_a[l]) mem[mem_addr_a[7:0]][8*l +: 8] <= mem_wdata_a[8*l +: 8];
      end else begin
        mem_rdata_a <= mem[mem_addr_a[7:0]];
      end
    end
  end

  int vectors = 0;
  int miscompares = 0;
  logic [32:0] exp_q_a[$];
  logic [32:0] exp_q_b[$];

  // Scoreboard: every completion pops the expectation pushed when its request was driven.
  always @(negedge clk) begin
    logic [32:0] e;
    if (resp_valid_a === 1'b1) begin
      vectors++;
      if (exp_q_a.size() == 0) begin
        miscompares++;
        $display("FAIL resp_a_unexpected got err=%b rdata=%h required no response", resp_err_a, resp_rdata_a);
      end else begin
        e = exp_q_a.pop_front();
        if ({resp_err_a, resp_rdata_a} !== e) begin
          miscompares++;
          $display("FAIL resp_a got err=%b rdata=%h required err=%b rdata=%h", resp_err_a, resp_rdata_a, e[32], e[31:0]);
        end
      end
      if (mem_en_a !== 1'b0) begin
        miscompares++;
        $display("FAIL resp_a_with_mem_en got mem_en=%b required 0", mem_en_a);
      end
    end
    if (resp_valid_b === 1'b1) begin
      vectors++;
      if (exp_q_b.size() == 0) begin
        miscompares++;
        $display("FAIL resp_b_unexpected got err=%b rdata=%h required no response", resp_err_b, resp_rdata_b);
      end else begin
        e = exp_q_b.pop_front();
        if ({resp_err_b, resp_rdata_b} !== e) begin
          miscompares++;
          $display("FAIL resp_b got err=%b rdata=%h required err=%b rdata=%h", resp_err_b, resp_rdata_b, e[32], e[31:0]);
        end
      end
    end
  end

  logic        tr_en   [1:6];
  logic        tr_we   [1:6];
  logic [3:0]  tr_strb [1:6];
  logic [29:0] tr_addr [1:6];
  logic [31:0] tr_wdata[1:6];
  int          resp_at;

  // Drives one request (called in the low clock phase), records the memory-side trace per cycle.
  task automatic send(input bit sel_b, input bit st, input logic [1:0] sz, input bit uns,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic exp_err, input logic [31:0] exp_rd);
    logic rdy;
    req_is_store = st; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    if (sel_b) begin req_valid_b = 1'b1; exp_q_b.push_back({exp_err, exp_rd}); end
    else       begin req_valid_a = 1'b1; exp_q_a.push_back({exp_err, exp_rd}); end
    #1;
    rdy = sel_b ? req_ready_b : req_ready_a;
    vectors++;
    if (rdy !== 1'b1) begin miscompares++; $display("FAIL req_ready got %b required 1", rdy); end
    @(posedge clk); #1;
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    resp_at = 0;
    for (int k = 1; k <= 6; k++) begin
      tr_en[k] = 1'b0; tr_we[k] = 1'b0; tr_strb[k] = '0; tr_addr[k] = '0; tr_wdata[k] = '0;
    end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      tr_en[k]    = sel_b ? mem_en_b    : mem_en_a;
      tr_we[k]    = sel_b ? mem_we_b    : mem_we_a;
      tr_strb[k]  = sel_b ? mem_wstrb_b : mem_wstrb_a;
      tr_addr[k]  = sel_b ? mem_addr_b  : mem_addr_a;
      tr_wdata[k] = sel_b ? mem_wdata_b : mem_wdata_a;
      if ((sel_b ? resp_valid_b : resp_valid_a) === 1'b1) begin resp_at = k; break; end
    end
    vectors++;
    if (resp_at == 0) begin miscompares++; $display("FAIL resp_timeout got none in 6 cycles required one"); end
    @(negedge clk);
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] sz, input bit uns);
    logic [31:0] v = 32'h0;
    logic [31:0] a;
    int n = 1 << sz;
    for (int i = 0; i < n; i++) begin
      a = addr + i;
      v[8*i +: 8] = mem[a[9:2]][8*a[1:0] +: 8];
    end
    if (!uns && v[8*n-1]) for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({req_ready_a, resp_valid_a, resp_err_a, resp_rdata_a, mem_en_a} !== 36'h0) begin
      miscompares++;
      $display("FAIL reset_outputs got rdy=%b rv=%b err=%b rd=%h en=%b required all 0",
               req_ready_a, resp_valid_a, resp_err_a, resp_rdata_a, mem_en_a);
    end
    rst = 1'b0; #1;
    vectors++;
    if (req_ready_a !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b required 1", req_ready_a); end
  endtask

  task automatic test_aligned_load();
    send(0, 0, 2'b10, 0, 32'h40, 32'h0, 1'b0, 32'h8899AABB);
    vectors++;
    if (resp_at !== 2) begin miscompares++; $display("FAIL lw_latency got %0d required 2", resp_at); end
    vectors++;
    if ({tr_en[1], tr_we[1], tr_strb[1], tr_addr[1], tr_en[2]} !== {1'b1, 1'b0, 4'h0, 30'h10, 1'b0}) begin
      miscompares++;
      $display("FAIL lw_mem got en=%b we=%b strb=%h addr=%h en2=%b required en=1 we=0 strb=0 addr=10 en2=0",
               tr_en[1], tr_we[1], tr_strb[1], tr_addr[1], tr_en[2]);
    end
  endtask

  task automatic test_extend();
    logic [1:0]  sz [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    bit          un [4] = '{0, 1, 0, 1};
    logic [31:0] ad [4] = '{32'h43, 32'h43, 32'h42, 32'h42};
    logic [31:0] ex [4] = '{32'hFFFFFF88, 32'h00000088, 32'hFFFF8899, 32'h00008899};
    for (int i = 0; i < 4; i++) begin
      send(0, 0, sz[i], un[i], ad[i], 32'h0, 1'b0, ex[i]);
      vectors++;
      if (resp_at !== 2) begin miscompares++; $display("FAIL ext_latency[%0d] got %0d required 2", i, resp_at); end
    end
  endtask

  task automatic test_split_load();
    send(0, 0, 2'b01, 0, 32'h43, 32'h0, 1'b0, 32'h00004488);
    vectors++;
    if ({resp_at[3:0], tr_en[1], tr_addr[1], tr_en[2], tr_addr[2]} !== {4'd3, 1'b1, 30'h10, 1'b1, 30'h11}) begin
      miscompares++;
      $display("FAIL lh_split got lat=%0d en1=%b a1=%h en2=%b a2=%h required lat=3 a1=10 a2=11",
               resp_at, tr_en[1], tr_addr[1], tr_en[2], tr_addr[2]);
    end
    send(0, 0, 2'b10, 0, 32'h42, 32'h0, 1'b0, 32'h33448899);
    vectors++;
    if (resp_at !== 3) begin miscompares++; $display("FAIL lw_split_latency got %0d required 3", resp_at); end
  endtask

  task automatic test_reset_mid_split();
    req_is_store = 0; req_size = 2'b01; req_unsigned = 0; req_addr = 32'h43; req_wdata = 0;
    req_valid_a = 1'b1;
    @(posedge clk); #1; req_valid_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({mem_en_a, mem_addr_a} !== {1'b1, 30'h11}) begin
      miscompares++; $display("FAIL mid_split_hi got en=%b addr=%h required en=1 addr=11", mem_en_a, mem_addr_a);
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({mem_en_a, resp_valid_a, resp_err_a, resp_rdata_a} !== 35'h0) begin
      miscompares++;
      $display("FAIL mid_split_reset got en=%b rv=%b err=%b rd=%h required all 0", mem_en_a, resp_valid_a, resp_err_a, resp_rdata_a);
    end
    rst = 1'b0; #1;
    vectors++;
    if (req_ready_a !== 1'b1) begin miscompares++; $display("FAIL mid_split_ready got %b required 1", req_ready_a); end
    repeat (2) @(negedge clk);
    send(0, 0, 2'b10, 0, 32'h44, 32'h0, 1'b0, 32'h11223344);
  endtask

  task automatic test_split_store();
    send(0, 1, 2'b10, 0, 32'h46, 32'hDEADBEEF, 1'b0, 32'h0);
    vectors++;
    if ({tr_en[1], tr_we[1], tr_addr[1], tr_strb[1], tr_wdata[1]} !== {1'b1, 1'b1, 30'h11, 4'hC, 32'hBEEF0000}) begin
      miscompares++;
      $display("FAIL sw_lo got en=%b we=%b a=%h s=%h d=%h required 1 1 11 C BEEF0000",
               tr_en[1], tr_we[1], tr_addr[1], tr_strb[1], tr_wdata[1]);
    end
    vectors++;
    if ({tr_en[2], tr_we[2], tr_addr[2], tr_strb[2], tr_wdata[2]} !== {1'b1, 1'b1, 30'h12, 4'h3, 32'h0000DEAD}) begin
      miscompares++;
      $display("FAIL sw_hi got en=%b we=%b a=%h s=%h d=%h required 1 1 12 3 0000DEAD",
               tr_en[2], tr_we[2], tr_addr[2], tr_strb[2], tr_wdata[2]);
    end
    vectors++;
    if (resp_at !== 3) begin miscompares++; $display("FAIL sw_latency got %0d required 3", resp_at); end
    send(0, 0, 2'b10, 0, 32'h44, 32'h0, 1'b0, 32'hBEEF3344);
  endtask

  task automatic test_errors();
    send(1, 0, 2'b01, 0, 32'h43, 32'h0, 1'b1, 32'h0);
    vectors++;
    if ({resp_at[3:0], tr_en[1]} !== {4'd1, 1'b0}) begin
      miscompares++; $display("FAIL b_misaligned got lat=%0d en=%b required lat=1 en=0", resp_at, tr_en[1]);
    end
    send(1, 0, 2'b11, 0, 32'h40, 32'h0, 1'b1, 32'h0);
    vectors++;
    if (resp_at !== 1) begin miscompares++; $display("FAIL b_rsv_latency got %0d required 1", resp_at); end
    send(0, 0, 2'b11, 0, 32'h40, 32'h0, 1'b1, 32'h0);
    vectors++;
    if ({resp_at[3:0], tr_en[1]} !== {4'd1, 1'b0}) begin
      miscompares++; $display("FAIL a_rsv got lat=%0d en=%b required lat=1 en=0", resp_at, tr_en[1]);
    end
    send(1, 0, 2'b01, 1, 32'h42, 32'h0, 1'b0, 32'h0);
    vectors++;
    if ({resp_at[3:0], tr_en[1], tr_addr[1]} !== {4'd2, 1'b1, 30'h10}) begin
      miscompares++; $display("FAIL b_aligned got lat=%0d en=%b a=%h required lat=2 en=1 a=10", resp_at, tr_en[1], tr_addr[1]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [1:0]  sz;
    bit          un;
    int          lat;
    for (int i = 0; i < 10; i++) begin
      a  = 32'h40 + $urandom_range(0, 7);
      sz = 2'($urandom_range(0, 2));
      un = 1'($urandom_range(0, 1));
      lat = (int'(a[1:0]) + (1 << sz) > 4) ? 3 : 2;
      send(0, 0, sz, un, a, 32'h0, 1'b0, model_load(a, sz, un));
      vectors++;
      if (resp_at !== lat) begin
        miscompares++; $display("FAIL rand_latency addr=%h size=%0d got %0d required %0d", a, sz, resp_at, lat);
      end
    end
  endtask

  initial begin
    req_valid_a = 0; req_valid_b = 0; req_is_store = 0; req_size = 0;
    req_unsigned = 0; req_addr = 0; req_wdata = 0;
    test_reset();
    test_aligned_load();
    test_extend();
    test_split_load();
    test_reset_mid_split();
    test_split_store();
    test_errors();
    test_back_to_back();
    repeat (3) @(negedge clk);
    vectors++;
    if (exp_q_a.size() + exp_q_b.size() != 0) begin
      miscompares++; $display("FAIL pending_responses got %0d outstanding required 0", exp_q_a.size() + exp_q_b.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
